// File: rtl/debounced_edge_detector.sv
`default_nettype none
// ============================================================================
// Module   : debounced_edge_detector
// Brief    : Multi-channel button front end. Each channel synchronises its raw
//            input, debounces it with a stability counter, and emits a
//            one-clock pulse on the debounced edge type selected by mode.
//            Optional macro HOLD_REPEAT_EN adds auto-repeat pulses while a
//            button is held, in the rising and both-edge modes.
// Revision : 1.0 - initial release
// ============================================================================
module debounced_edge_detector #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 50000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
  input  logic [1:0]          mode,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pulse
);

  localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] c_mode_rise = 2'b00;
  localparam logic [1:0] c_mode_fall = 2'b01;
  localparam logic [1:0] c_mode_both = 2'b10;

  // Reject configurations the channel logic cannot support.
  if ((CHANNELS < 1) || (SYNC_STAGES < 2) || (DEBOUNCE_CYCLES < 1) ||
      (REPEAT_CYCLES < 2)) begin : g_bad_params
    $error("debounced_edge_detector: illegal parameter value");
  end

  // Mode decode shared by all channels; 11 enables neither direction.
  logic w_rise_en;
  logic w_fall_en;
  assign w_rise_en = (mode == c_mode_rise) || (mode == c_mode_both);
  assign w_fall_en = (mode == c_mode_fall) || (mode == c_mode_both);

`ifdef HOLD_REPEAT_EN
  localparam int c_rep_w = $clog2(REPEAT_CYCLES);
  localparam logic [c_rep_w-1:0] c_rep_last = c_rep_w'(REPEAT_CYCLES - 1);
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_level;
    logic                   r_pulse;
    logic                   w_s;
    logic                   w_flip;
    logic                   w_flip_pulse;
    logic                   w_rep_pulse;

    assign w_s          = r_sync[SYNC_STAGES-1];
    // The debounced level flips on the edge where the mismatch has lasted
    // the full stability window.
    assign w_flip       = (w_s != r_level) && (r_cnt == c_cnt_last);
    assign w_flip_pulse = w_flip && (w_s ? w_rise_en : w_fall_en);

    // Synchroniser chain bringing the asynchronous button into clk.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], in[g]};
      end
    end

    // Stability counter: any return to the current level restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else if (w_s == r_level) begin
        r_cnt   <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_level <= w_s;
        r_cnt   <= '0;
      end else begin
        r_cnt   <= r_cnt + c_cnt_w'(1);
      end
    end

`ifdef HOLD_REPEAT_EN
    logic [c_rep_w-1:0] r_rep;

    // Hold-to-repeat timer; runs only while pressed in a rising-edge mode.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rep <= '0;
      end else if (!r_level || !w_rise_en) begin
        r_rep <= '0;
      end else if (r_rep == c_rep_last) begin
        r_rep <= '0;
      end else begin
        r_rep <= r_rep + c_rep_w'(1);
      end
    end

    assign w_rep_pulse = r_level && w_rise_en && (r_rep == c_rep_last);
`else
    assign w_rep_pulse = 1'b0;
`endif

    // Pulse is registered alongside the level so both change on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= w_flip_pulse | w_rep_pulse;
      end
    end

    assign level[g] = r_level;
    assign pulse[g] = r_pulse;
  end

endmodule
`default_nettype wire

// File: tb/tb_debounced_edge_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounced_edge_detector
// Brief    : Self-checking bench for debounced_edge_detector with a history-
//            window reference model and directed button scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounced_edge_detector;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int DC = 4;
  localparam int RC = 10;
  // Raw-input history needed to see the last DC synchronised samples.
  localparam int HL = SS + DC - 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] din   = '0;
  logic [1:0]    mode  = 2'b00;
  logic [CH-1:0] level;
  logic [CH-1:0] pulse;

  int tests = 0;
  int fails = 0;

  debounced_edge_detector #(
    .CHANNELS       (CH),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_CYCLES  (RC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (din),
    .mode (mode),
    .level(level),
    .pulse(pulse)
  );

  always #5 clk = ~clk;

  // Reference model: keep the raw samples; the level flips when the last DC
  // synchronised samples all disagree with it.
  logic [HL-1:0] m_hist [CH];
  logic [CH-1:0] m_level, m_pulse, n_level, n_pulse;
`ifdef HOLD_REPEAT_EN
  int m_rep [CH];
  int n_rep [CH];
`endif

  always_comb begin
    n_level = m_level;
    n_pulse = '0;
`ifdef HOLD_REPEAT_EN
    n_rep = m_rep;
`endif
    for (int c = 0; c < CH; c++) begin
      if (!m_level[c] && (&m_hist[c][HL-1:SS-1])) begin
        n_level[c] = 1'b1;
        n_pulse[c] = (mode == 2'b00) || (mode == 2'b10);
      end else if (m_level[c] && !(|m_hist[c][HL-1:SS-1])) begin
        n_level[c] = 1'b0;
        n_pulse[c] = (mode == 2'b01) || (mode == 2'b10);
      end
`ifdef HOLD_REPEAT_EN
      if (!m_level[c] || mode[0]) begin
        n_rep[c] = 0;
      end else if (m_rep[c] == RC - 1) begin
        n_rep[c]   = 0;
        n_pulse[c] = 1'b1;
      end else begin
        n_rep[c] = m_rep[c] + 1;
      end
`endif
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        m_hist[c] <= '0;
`ifdef HOLD_REPEAT_EN
        m_rep[c]  <= 0;
`endif
      end
      m_level <= '0;
      m_pulse <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        m_hist[c] <= {m_hist[c][HL-2:0], din[c]};
`ifdef HOLD_REPEAT_EN
        m_rep[c]  <= n_rep[c];
`endif
      end
      m_level <= n_level;
      m_pulse <= n_pulse;
    end
  end

  // Every-cycle comparison of DUT against the model, away from the clock edge.
  always @(negedge clk) begin
    tests++;
    if (level !== m_level) begin
      fails++;
      $display("FAIL model_level: got %b expected %b at %0t", level, m_level, $time);
    end
    tests++;
    if (pulse !== m_pulse) begin
      fails++;
      $display("FAIL model_pulse: got %b expected %b at %0t", pulse, m_pulse, $time);
    end
  end

  task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic count_pulses(input int cycles, input int ch, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (pulse[ch]) n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n1;
    int n2;
    int found;

    // Reset held: everything zero.
    repeat (3) @(negedge clk);
    chk("reset_level", level, 4'b0000);
    chk("reset_pulse", pulse, 4'b0000);
    rst_n = 1'b1;

    // Clean step on ch0: level rises on the 6th edge counting the sampling edge.
    @(negedge clk);
    din = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("step_wait_level", level, 4'b0000);
    end
    @(negedge clk);
    chk("step_level", level, 4'b0001);
    chk("step_pulse", pulse, 4'b0001);
    chk("step_model_level", m_level, 4'b0001);
    @(negedge clk);
    chk("step_pulse_gone", pulse, 4'b0000);

    // 3-cycle glitch on ch1 is filtered.
    din = 4'b0011;
    repeat (3) @(negedge clk);
    din = 4'b0001;
    count_pulses(15, 1, n1);
    chk_int("glitch_pulses", n1, 0);
    chk("glitch_level", level, 4'b0001);

    // 4-cycle stable high on ch1 passes with exactly one pulse.
    din = 4'b0011;
    count_pulses(4, 1, n1);
    din = 4'b0001;
    count_pulses(15, 1, n2);
    chk_int("press4_pulses", n1 + n2, 1);
    chk("press4_level_after", level, 4'b0001);

    // Falling mode on ch2: nothing on press, one on release.
    mode = 2'b01;
    din  = 4'b0101;
    count_pulses(12, 2, n1);
    chk_int("fall_mode_press", n1, 0);
    chk("fall_mode_level", level, 4'b0101);
    din = 4'b0001;
    count_pulses(12, 2, n1);
    chk_int("fall_mode_release", n1, 1);

    // Both-edge mode: two pulses.
    mode = 2'b10;
    din  = 4'b0101;
    count_pulses(12, 2, n1);
    din = 4'b0001;
    count_pulses(12, 2, n2);
    chk_int("both_mode_pulses", n1 + n2, 2);

    // Disabled mode: level tracks, no pulses.
    mode = 2'b11;
    din  = 4'b0101;
    count_pulses(12, 2, n1);
    chk("off_mode_level_hi", level, 4'b0101);
    din = 4'b0001;
    count_pulses(12, 2, n2);
    chk_int("off_mode_pulses", n1 + n2, 0);
    chk("off_mode_level_lo", level, 4'b0001);

    // All channels at once in rising mode.
    mode = 2'b00;
    din  = 4'b0000;
    repeat (12) @(negedge clk);
    chk("all_clear_level", level, 4'b0000);
    din = 4'b1111;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    @(negedge clk);
    chk("all_level", level, 4'b1111);
    chk("all_pulse", pulse, 4'b1111);
    @(negedge clk);
    chk("all_pulse_gone", pulse, 4'b0000);

    // Reset halfway through a debounce count on ch0.
    din = 4'b0000;
    repeat (12) @(negedge clk);
    din = 4'b0001;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_level", level, 4'b0000);
    chk("midreset_pulse", pulse, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("midreset_wait_level", level, 4'b0000);
    end
    @(negedge clk);
    chk("midreset_rise_level", level, 4'b0001);
    chk("midreset_rise_pulse", pulse, 4'b0001);

`ifdef HOLD_REPEAT_EN
    // Hold ch3: repeats at +10, +20, +30 after the rising pulse.
    din = 4'b0000;
    repeat (12) @(negedge clk);
    din   = 4'b1000;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pulse[3]) begin
        found = 1;
        break;
      end
    end
    chk_int("repeat_first_pulse_seen", found, 1);
    n1 = 0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (pulse[3]) n1++;
      if (k == 30) din = 4'b0000;
    end
    chk_int("repeat_pulses", n1, 3);
    count_pulses(20, 3, n2);
    chk_int("repeat_after_release", n2, 0);
    chk("repeat_level_after", level, 4'b0000);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
